// File: rtl/jtag_pkg.sv
// Shared TAP state encoding and constants used by the JTAG blocks.
package jtag_pkg;

    // Encoding follows the IEEE 1149.1 example so states read naturally on a logic analyser.
    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RTI        = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_state_t;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller with decoded state strobes.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state,
    output logic       is_tlr,
    output logic       is_capture_dr,
    output logic       is_shift_dr,
    output logic       is_update_dr,
    output logic       is_capture_ir,
    output logic       is_shift_ir,
    output logic       is_update_ir
);

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state <= TLR;
        end else begin
            case (state)
                TLR:        state <= TMS ? TLR        : RTI;
                RTI:        state <= TMS ? SELECT_DR  : RTI;
                SELECT_DR:  state <= TMS ? SELECT_IR  : CAPTURE_DR;
                CAPTURE_DR: state <= TMS ? EXIT1_DR   : SHIFT_DR;
                SHIFT_DR:   state <= TMS ? EXIT1_DR   : SHIFT_DR;
                EXIT1_DR:   state <= TMS ? UPDATE_DR  : PAUSE_DR;
                PAUSE_DR:   state <= TMS ? EXIT2_DR   : PAUSE_DR;
                EXIT2_DR:   state <= TMS ? UPDATE_DR  : SHIFT_DR;
                UPDATE_DR:  state <= TMS ? SELECT_DR  : RTI;
                SELECT_IR:  state <= TMS ? TLR        : CAPTURE_IR;
                CAPTURE_IR: state <= TMS ? EXIT1_IR   : SHIFT_IR;
                SHIFT_IR:   state <= TMS ? EXIT1_IR   : SHIFT_IR;
                EXIT1_IR:   state <= TMS ? UPDATE_IR  : PAUSE_IR;
                PAUSE_IR:   state <= TMS ? EXIT2_IR   : PAUSE_IR;
                EXIT2_IR:   state <= TMS ? UPDATE_IR  : SHIFT_IR;
                UPDATE_IR:  state <= TMS ? SELECT_DR  : RTI;
                default:    state <= TLR;
            endcase
        end
    end

    assign is_tlr        = (state == TLR);
    assign is_capture_dr = (state == CAPTURE_DR);
    assign is_shift_dr   = (state == SHIFT_DR);
    assign is_update_dr  = (state == UPDATE_DR);
    assign is_capture_ir = (state == CAPTURE_IR);
    assign is_shift_ir   = (state == SHIFT_IR);
    assign is_update_ir  = (state == UPDATE_IR);

endmodule

// File: rtl/jtag_tap_core.sv
// TAP core: FSM, instruction register, BYPASS/IDCODE registers, decode and
// falling-edge TDO driver, with strobes for externally hosted user DRs.
module jtag_tap_core
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VAL   = 32'h0000_0001,
    parameter int          IDCODE_INSTR = 1,
    parameter int          USER_BASE    = 8,
    parameter int          NUM_USER     = 2
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic                tlr,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic [NUM_USER-1:0] user_sel,
    input  logic [NUM_USER-1:0] user_tdo
);

    localparam logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(IDCODE_INSTR);
    localparam logic [IR_WIDTH-1:0] BYPASS_OP  = '1;
    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);

    tap_state_t            state;
    logic                  is_tlr, is_capture_dr, is_shift_dr, is_update_dr;
    logic                  is_capture_ir, is_shift_ir, is_update_ir;
    logic [IR_WIDTH-1:0]   ir_shift;
    logic                  bypass_reg;
    logic [31:0]           idcode_reg;
    logic                  sel_bypass, sel_idcode;
    logic [NUM_USER-1:0]   user_hit;
    logic                  tdo_next;

    jtag_tap_fsm u_fsm (
        .TCK           (TCK),
        .TRST          (TRST),
        .TMS           (TMS),
        .state         (state),
        .is_tlr        (is_tlr),
        .is_capture_dr (is_capture_dr),
        .is_shift_dr   (is_shift_dr),
        .is_update_dr  (is_update_dr),
        .is_capture_ir (is_capture_ir),
        .is_shift_ir   (is_shift_ir),
        .is_update_ir  (is_update_ir)
    );

    // All-ones wins over everything, then IDCODE, then the user window; anything else is BYPASS.
    always_comb begin
        sel_bypass = 1'b0;
        sel_idcode = 1'b0;
        user_hit   = '0;
        if (ir_out == BYPASS_OP) begin
            sel_bypass = 1'b1;
        end else if (ir_out == IDCODE_OP) begin
            sel_idcode = 1'b1;
        end else begin
            for (int k = 0; k < NUM_USER; k++) begin
                if (ir_out == IR_WIDTH'(USER_BASE + k)) user_hit[k] = 1'b1;
            end
            sel_bypass = ~|user_hit;
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_shift   <= '0;
            bypass_reg <= 1'b0;
            idcode_reg <= IDCODE_VAL;
        end else begin
            if (is_capture_ir)
                ir_shift <= IR_CAP_VAL;
            else if (is_shift_ir)
                ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};

            if (sel_bypass && is_capture_dr)
                bypass_reg <= 1'b0;
            else if (sel_bypass && is_shift_dr)
                bypass_reg <= TDI;

            if (sel_idcode && is_capture_dr)
                idcode_reg <= IDCODE_VAL;
            else if (sel_idcode && is_shift_dr)
                idcode_reg <= {TDI, idcode_reg[31:1]};
        end
    end

    always_comb begin
        if (is_shift_ir)
            tdo_next = ir_shift[0];
        else if (sel_idcode)
            tdo_next = idcode_reg[0];
        else if (|user_hit)
            tdo_next = |(user_tdo & user_hit);
        else
            tdo_next = bypass_reg;
    end

    // Falling-edge side: the instruction latch and TDO driver settle while TCK is low.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_out <= IDCODE_OP;
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            if (is_tlr)
                ir_out <= IDCODE_OP;
            else if (is_update_ir)
                ir_out <= ir_shift;
            TDO    <= tdo_next;
            TDO_EN <= is_shift_ir | is_shift_dr;
        end
    end

    assign tlr        = is_tlr;
    assign user_sel   = user_hit;
    assign capture_dr = is_capture_dr & (|user_hit);
    assign shift_dr   = is_shift_dr & (|user_hit);
    assign update_dr  = is_update_dr & (|user_hit);

endmodule

// File: tb/tb_jtag_tap_core.sv
// Scoreboard bench for jtag_tap_core: scans push expected TDO bits, a
// falling-edge monitor pops and compares them whenever TDO_EN is high.
module tb_jtag_tap_core;

    localparam int          IR_WIDTH     = 4;
    localparam logic [31:0] IDCODE_VAL   = 32'h0000_0001;
    localparam logic [3:0]  IDCODE_INSTR = 4'h1;
    localparam int          USER_BASE    = 8;
    localparam int          NUM_USER     = 2;

    logic       TCK = 1'b0;
    logic       TRST = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO, TDO_EN;
    logic [3:0] ir_out;
    logic       tlr, capture_dr, shift_dr, update_dr;
    logic [1:0] user_sel;
    logic [1:0] user_tdo = 2'b00;

    int         errors = 0;
    int         checks = 0;
    logic       exp_q[$];
    bit         sb_enable = 1'b0;
    int         cnt_cap = 0, cnt_shift = 0, cnt_upd = 0;
    logic [3:0] model_ir = IDCODE_INSTR;

    jtag_tap_core #(
        .IR_WIDTH     (IR_WIDTH),
        .IDCODE_VAL   (IDCODE_VAL),
        .IDCODE_INSTR (int'(IDCODE_INSTR)),
        .USER_BASE    (USER_BASE),
        .NUM_USER     (NUM_USER)
    ) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO),
        .TDO_EN     (TDO_EN),
        .ir_out     (ir_out),
        .tlr        (tlr),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .user_sel   (user_sel),
        .user_tdo   (user_tdo)
    );

    always #5 TCK = ~TCK;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic tms, input logic tdi);
        @(negedge TCK);
        #1;
        TMS      = tms;
        TDI      = tdi;
        user_tdo = 2'($urandom_range(0, 3));
    endtask

    task automatic settle();
        @(negedge TCK);
        #1;
    endtask

    // Reference: which user DR (if any) an opcode selects, straight from the decode rules.
    function automatic int model_user_index(input logic [3:0] op);
        if (op == 4'hF || op == IDCODE_INSTR) return -1;
        if (int'(op) >= USER_BASE && int'(op) < USER_BASE + NUM_USER) return int'(op) - USER_BASE;
        return -1;
    endfunction

    task automatic push_expected(input int i, input int k, input int len,
                                 input logic [63:0] cap, input logic [63:0] tdi);
        if (k >= 0)
            exp_q.push_back(user_tdo[k]);
        else if (i < len)
            exp_q.push_back(cap[i]);
        else
            exp_q.push_back(tdi[i-len]);
    endtask

    task automatic ir_scan(input logic [3:0] v);
        logic [3:0] cap_pat;
        int         k;
        cap_pat = 4'b0001;
        for (int i = 0; i < IR_WIDTH; i++) exp_q.push_back(cap_pat[i]);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        for (int j = 0; j < IR_WIDTH; j++) apply_stimulus(j == IR_WIDTH-1, v[j]);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        model_ir = v;
        k = model_user_index(v);
        check_output("ir_out_after_update", 32'(ir_out), 32'(v));
        check_output("user_sel_decode", 32'(user_sel), (k >= 0) ? 32'(1 << k) : 32'h0);
        check_output("ir_tdo_queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic dr_scan(input int n, input logic [63:0] tdi);
        int          k;
        int          len;
        logic [63:0] cap;
        k = model_user_index(model_ir);
        if (k < 0 && model_ir == IDCODE_INSTR) begin
            len = 32;
            cap = {32'h0, IDCODE_VAL};
        end else begin
            len = 1;
            cap = '0;
        end
        cnt_cap   = 0;
        cnt_shift = 0;
        cnt_upd   = 0;
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        push_expected(0, k, len, cap, tdi);
        for (int j = 0; j < n; j++) begin
            apply_stimulus(j == n-1, tdi[j]);
            if (j < n-1) push_expected(j+1, k, len, cap, tdi);
        end
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check_output("dr_tdo_queue_drained", 32'(exp_q.size()), 32'h0);
        check_output("capture_dr_count", 32'(cnt_cap), (k >= 0) ? 32'h1 : 32'h0);
        check_output("shift_dr_count", 32'(cnt_shift), (k >= 0) ? 32'(n) : 32'h0);
        check_output("update_dr_count", 32'(cnt_upd), (k >= 0) ? 32'h1 : 32'h0);
    endtask

    initial begin : monitor
        logic e;
        forever begin
            @(negedge TCK);
            #2;
            if (capture_dr) cnt_cap++;
            if (shift_dr) cnt_shift++;
            if (update_dr) cnt_upd++;
            if (sb_enable && TDO_EN) begin
                if (exp_q.size() == 0) begin
                    check_output("tdo_en_unexpected", 32'(TDO_EN), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("tdo_bit", 32'(TDO), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int          steps;
        logic [63:0] d;

        #1 TRST = 1'b0;
        #2;
        check_output("reset_tlr", 32'(tlr), 32'h1);
        check_output("reset_ir_out", 32'(ir_out), 32'(IDCODE_INSTR));
        check_output("reset_tdo", 32'(TDO), 32'h0);
        check_output("reset_tdo_en", 32'(TDO_EN), 32'h0);
        check_output("reset_user_sel", 32'(user_sel), 32'h0);
        check_output("reset_strobes", 32'({capture_dr, shift_dr, update_dr}), 32'h0);
        @(negedge TCK);
        #1 TRST = 1'b1;
        sb_enable = 1'b1;

        // Enter SHIFT_DR, then five TMS=1 edges must land in TLR and not sooner.
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        exp_q.push_back(IDCODE_VAL[0]);
        apply_stimulus(1'b0, 1'b0);
        repeat (5) apply_stimulus(1'b1, 1'b0);
        check_output("tlr_after_four_ones", 32'(tlr), 32'h0);
        settle();
        check_output("tlr_after_five_ones", 32'(tlr), 32'h1);
        check_output("ir_out_in_tlr", 32'(ir_out), 32'(IDCODE_INSTR));
        check_output("short_scan_drained", 32'(exp_q.size()), 32'h0);
        apply_stimulus(1'b0, 1'b0);

        dr_scan(32, 64'h0);

        ir_scan(4'hF);
        dr_scan(8, 64'hB2);

        ir_scan(4'h9);
        dr_scan(12, {$urandom, $urandom});
        ir_scan(4'h8);
        dr_scan(5, {$urandom, $urandom});
        ir_scan(4'h5);
        dr_scan(10, {$urandom, $urandom});

        for (int it = 0; it < 12; it++) begin
            ir_scan(4'($urandom_range(0, 15)));
            d = {$urandom, $urandom};
            dr_scan($urandom_range(1, 40), d);
        end

        // Random walks through the graph; five TMS=1 edges must always recover TLR.
        sb_enable = 1'b0;
        for (int w = 0; w < 6; w++) begin
            steps = $urandom_range(3, 20);
            for (int s = 0; s < steps; s++) apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat (5) apply_stimulus(1'b1, 1'b0);
            settle();
            check_output("walk_tlr", 32'(tlr), 32'h1);
            check_output("walk_ir_out", 32'(ir_out), 32'(IDCODE_INSTR));
        end
        exp_q.delete();
        sb_enable = 1'b1;
        apply_stimulus(1'b0, 1'b0);
        model_ir = IDCODE_INSTR;

        // TRST in the middle of an IR scan after two shifted bits.
        ir_scan(4'h9);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
        @(negedge TCK);
        #3 TRST = 1'b0;
        #1;
        check_output("trst_tdo_en", 32'(TDO_EN), 32'h0);
        check_output("trst_tlr", 32'(tlr), 32'h1);
        check_output("trst_ir_out", 32'(ir_out), 32'(IDCODE_INSTR));
        check_output("trst_user_sel", 32'(user_sel), 32'h0);
        check_output("trst_scan_drained", 32'(exp_q.size()), 32'h0);
        @(negedge TCK);
        #1 TRST = 1'b1;
        model_ir = IDCODE_INSTR;
        dr_scan(32, {$urandom, $urandom});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised IEEE 1149.1 TAP core: the 16-state TAP FSM plus an integrated instruction register of width IR_WIDTH, BYPASS and IDCODE data registers, instruction decode, and a falling-edge TDO driver. It sits directly behind the JTAG pins. It exports capture/shift/update strobes and one-hot select lines so that NUM_USER external data registers can hang off the chain without their own FSM.

## Interface
- IR_WIDTH, 4: instruction register width, minimum 2.
- IDCODE_VAL, 32'h0000_0001: IDCODE DR contents; bit 0 must be 1.
- IDCODE_INSTR, 1: opcode selecting IDCODE; also the reset instruction.
- USER_BASE, 8: opcode of user DR 0; user k = USER_BASE+k.
- NUM_USER, 2: number of external user DRs, 1..8.
- TCK  in  1  test clock; all state changes on its edges.
- TRST  in  1  reset, asynchronous, active-low.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial data in, sampled on posedge TCK.
- TDO  out  1  serial data out, registered on negedge TCK.
- TDO_EN  out  1  output enable, registered on negedge TCK.
- ir_out  out  IR_WIDTH  current latched instruction.
- tlr  out  1  state == TEST_LOGIC_RESET.
- capture_dr, shift_dr, update_dr  out  1  state decodes; gated by any user_sel bit being high.
- user_sel  out  NUM_USER  one-hot select of the active user DR; all zero otherwise.
- user_tdo  in  NUM_USER  serial outputs of the user DRs.

## Operation
- FSM: standard 1149.1 graph: TLR, RTI, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the IR equivalents. Transitions per TMS exactly as in the standard.
- Out-of-range encodings go to TLR.
- Five consecutive TMS=1 edges reach TLR from any state.
- IR shift register:
  - Captures {IR_WIDTH-2 zeros, 2'b01} on the posedge leaving CAPTURE_IR.
  - Shifts right in SHIFT_IR: TDI enters the MSB, the LSB goes to TDO.
- Instruction latch (ir_out):
  - Loads the shift register on negedge TCK while in UPDATE_IR.
  - Forced to IDCODE_INSTR on negedge while in TLR and asynchronously by TRST.
- DR decode from ir_out:
  - All-ones selects BYPASS.
  - IDCODE_INSTR selects IDCODE.
  - USER_BASE..USER_BASE+NUM_USER-1 selects a user DR and raises user_sel[k].
  - Any other opcode selects BYPASS.
- BYPASS: 1 bit. Captures 0, shifts TDI.
- IDCODE: 32 bits. Captures IDCODE_VAL, shifts right with TDI into bit 31.
- User DRs: the core only muxes user_tdo[k]. The strobes tell the external register when to act.
- Registers not in CAPTURE/SHIFT hold their value. PAUSE holds all shift contents.

## Timing
- State register: posedge TCK, async reset to TLR.
- Capture/shift take effect on the posedge on which the FSM is in that state, i.e. the edge leaving it.
- TDO mux:
  - Source is the IR LSB in SHIFT_IR, else the selected DR LSB or user_tdo[k].
  - Registered on negedge TCK.
  - TDO_EN = 1 only while in SHIFT_IR/SHIFT_DR, also registered on negedge.
  - Bit 0 of a scan appears on TDO half a cycle after entering SHIFT.
- Reset values:
  - State TLR.
  - ir_out = IDCODE_INSTR.
  - IR shift register = 0, BYPASS = 0, IDCODE register = IDCODE_VAL.
  - TDO = 0, TDO_EN = 0, user_sel = 0.
  - tlr = 1; capture_dr/shift_dr/update_dr = 0.
- TRST mid-scan:
  - Immediate return to TLR; the partial IR is discarded and ir_out returns to IDCODE_INSTR.
  - TDO_EN drops asynchronously.
- Exiting SHIFT_IR without UPDATE_IR (via TLR) leaves ir_out unchanged until the TLR negedge forces IDCODE_INSTR.
- Latency: an IR scan affects DR selection from the negedge in UPDATE_IR. The following CAPTURE_DR uses the new instruction.

## Structure
- Package jtag_pkg:
  - 4-bit state localparams using the 1149.1 example encoding (TLR=F, RTI=C, SELECT_DR=7, CAPTURE_DR=6, SHIFT_DR=2, EXIT1_DR=1, PAUSE_DR=3, EXIT2_DR=0, UPDATE_DR=5, SELECT_IR=4, CAPTURE_IR=E, SHIFT_IR=A, EXIT1_IR=9, PAUSE_IR=B, EXIT2_IR=8, UPDATE_IR=D).
  - IR capture pattern constant.
- Sub-module jtag_tap_fsm:
  - Inputs TCK, TRST, TMS.
  - Outputs state plus one-hot decodes.
  - Reusable by other JTAG blocks.
- Top: IR, DR registers, decode, TDO mux.

## Test plan
- TRST low, release, then 5×TMS=1 from SHIFT_DR -> tlr=1, ir_out=4'h1.
- After reset, DR scan of 32 bits with TDI=0 -> TDO yields 32'h0000_0001 LSB first; TDO_EN high exactly those 32 negedges.
- IR scan shifting 4'hF -> TDO yields 1,0,0,0 (capture pattern). Then DR scan of 8 bits TDI=8'b1011_0010 -> TDO is a 0 followed by TDI delayed one bit.
- IR scan loading 4'h9 -> user_sel=2'b10. DR scan gates capture_dr/shift_dr/update_dr, and TDO follows user_tdo[1].
- IR scan loading 4'h5 (undefined) -> BYPASS behaviour, user_sel=0.
- TRST pulsed mid SHIFT_IR after 2 bits -> state TLR, ir_out=4'h1, TDO_EN=0 immediately; a subsequent DR scan returns IDCODE_VAL.
